// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller FSM encoding, MISR polynomial and width,
// and the MISR next-state function reused by every compactor instance.
package bist_pkg;

    localparam int BIST_W = 8;
    localparam logic [BIST_W-1:0] BIST_POLY = 8'h1D;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } bist_state_t;

    function automatic logic [BIST_W-1:0] misr_next(input logic [BIST_W-1:0] sig,
                                                    input logic [BIST_W-1:0] d);
        logic [BIST_W-1:0] shifted;
        shifted = {sig[BIST_W-2:0], 1'b0} ^ (sig[BIST_W-1] ? BIST_POLY : '0);
        return shifted ^ d;
    endfunction

endpackage

// File: rtl/bist_controller_misr.sv
// 8-bit multiple-input signature register; clr has priority over en so a new
// session always starts from a known seed.
module misr_8
    import bist_pkg::*;
#(
    parameter logic [BIST_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [BIST_W-1:0] clr_val,
    input  logic              en,
    input  logic [BIST_W-1:0] d,
    output logic [BIST_W-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= RST_VAL;
        end else if (clr) begin
            sig <= clr_val;
        end else if (en) begin
            sig <= misr_next(sig, d);
        end
    end

endmodule

// File: rtl/bist_controller.sv
// BIST session sequencer: holds/releases the pattern LFSR, compacts CUT responses
// delayed by CUT_LAT cycles, and grades the final signature against GOLDEN_SIG.
module bist_controller
    import bist_pkg::*;
#(
    parameter int                PATTERN_COUNT = 255,
    parameter int                CUT_LAT       = 0,
    parameter logic [BIST_W-1:0] MISR_SEED     = 8'h00,
    parameter logic [BIST_W-1:0] GOLDEN_SIG    = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BIST_W-1:0] cut_resp,
    output logic              lfsr_rst,
    output logic              test_mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [BIST_W-1:0] signature,
    output logic [15:0]       pattern_cnt
);

    if (PATTERN_COUNT < 1 || PATTERN_COUNT > 65535) begin : g_bad_count
        $error("bist_controller: PATTERN_COUNT must be 1..65535");
    end
    if (CUT_LAT < 0 || CUT_LAT > 3) begin : g_bad_lat
        $error("bist_controller: CUT_LAT must be 0..3");
    end

    localparam logic [15:0] CNT_LAST   = 16'(PATTERN_COUNT - 1);
    localparam logic [1:0]  FLUSH_LAST = (CUT_LAT > 0) ? 2'(CUT_LAT - 1) : 2'd0;

    bist_state_t state_q, state_d;
    logic [1:0]  flush_cnt;
    logic        run_now;
    logic        misr_en;

    assign run_now = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SEED;
            S_SEED:  state_d = S_RUN;
            S_RUN:   if (pattern_cnt == CNT_LAST) state_d = (CUT_LAT > 0) ? S_FLUSH : S_CHECK;
            S_FLUSH: if (flush_cnt == FLUSH_LAST) state_d = S_CHECK;
            S_CHECK: state_d = S_DONE;
            S_DONE:  if (start) state_d = S_SEED;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_rst    <= 1'b1;
            test_mode   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            pattern_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            lfsr_rst  <= (state_d != S_RUN);
            test_mode <= (state_d inside {S_SEED, S_RUN, S_FLUSH, S_CHECK});
            busy      <= (state_d inside {S_SEED, S_RUN, S_FLUSH, S_CHECK});
            done      <= (state_d == S_DONE);
            flush_cnt <= (state_q == S_FLUSH) ? flush_cnt + 2'd1 : 2'd0;

            if (state_d == S_SEED) begin
                pattern_cnt <= '0;
                pass        <= 1'b0;
            end else begin
                if (run_now && pattern_cnt != 16'hFFFF) pattern_cnt <= pattern_cnt + 16'd1;
                if (state_q == S_CHECK) pass <= (signature == GOLDEN_SIG);
            end
        end
    end

    // Stage boundary: RUN flag delayed to meet the CUT response it belongs to.
    if (CUT_LAT == 0) begin : g_no_lat
        assign misr_en = run_now;
    end else begin : g_lat
        logic [CUT_LAT-1:0] vld_p;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= run_now;
                for (int i = 1; i < CUT_LAT; i++) vld_p[i] <= vld_p[i-1];
            end
        end
        assign misr_en = vld_p[CUT_LAT-1];
    end

    misr_8 #(
        .RST_VAL (MISR_SEED)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_d == S_SEED),
        .clr_val (MISR_SEED),
        .en      (misr_en),
        .d       (cut_resp),
        .sig     (signature)
    );

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: five instances with different parameters,
// each fed by its own LFSR (seed 0xA5) and CUT model.
module tb_bist_controller;

    logic       clk;
    logic       rst;
    logic [5:1] start_v;
    logic [5:1] lrst_v;
    logic [5:1] tm_v;
    logic [5:1] busy_v;
    logic [5:1] done_v;
    logic [5:1] pass_v;
    logic [7:0] sig_v [1:5];
    logic [15:0] cnt_v [1:5];
    logic [7:0] cut_v [1:5];
    logic [7:0] lq [1:5];
    logic [7:0] c4a, c4b;

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    // Reference signature for an identity CUT after n patterns from seed 0xA5.
    function automatic logic [7:0] ref_sig(input int n);
        logic [7:0] l;
        logic [7:0] s;
        l = 8'hA5;
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            s = lfsr_step(s) ^ l;
            l = lfsr_step(l);
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 1; i <= 5; i++) lq[i] <= lrst_v[i] ? 8'hA5 : lfsr_step(lq[i]);
        c4a <= lq[4];
        c4b <= c4a;
    end

    assign cut_v[1] = lq[1];
    assign cut_v[2] = lq[2];
    assign cut_v[3] = lq[3];
    assign cut_v[4] = c4b;
    assign cut_v[5] = lq[5];

    bist_controller #(.PATTERN_COUNT(1), .CUT_LAT(0), .MISR_SEED(8'h00), .GOLDEN_SIG(8'hA5)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .cut_resp(cut_v[1]), .lfsr_rst(lrst_v[1]),
        .test_mode(tm_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .signature(sig_v[1]), .pattern_cnt(cnt_v[1]));
    bist_controller #(.PATTERN_COUNT(2), .CUT_LAT(0), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h00)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .cut_resp(cut_v[2]), .lfsr_rst(lrst_v[2]),
        .test_mode(tm_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .signature(sig_v[2]), .pattern_cnt(cnt_v[2]));
    bist_controller #(.PATTERN_COUNT(2), .CUT_LAT(0), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h5A)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .cut_resp(cut_v[3]), .lfsr_rst(lrst_v[3]),
        .test_mode(tm_v[3]), .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
        .signature(sig_v[3]), .pattern_cnt(cnt_v[3]));
    bist_controller #(.PATTERN_COUNT(255), .CUT_LAT(2), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h00)) u4 (
        .clk(clk), .rst(rst), .start(start_v[4]), .cut_resp(cut_v[4]), .lfsr_rst(lrst_v[4]),
        .test_mode(tm_v[4]), .busy(busy_v[4]), .done(done_v[4]), .pass(pass_v[4]),
        .signature(sig_v[4]), .pattern_cnt(cnt_v[4]));
    bist_controller #(.PATTERN_COUNT(255), .CUT_LAT(0), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h00)) u5 (
        .clk(clk), .rst(rst), .start(start_v[5]), .cut_resp(cut_v[5]), .lfsr_rst(lrst_v[5]),
        .test_mode(tm_v[5]), .busy(busy_v[5]), .done(done_v[5]), .pass(pass_v[5]),
        .signature(sig_v[5]), .pattern_cnt(cnt_v[5]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Runs one session; returns start-to-done cycle count, RUN cycles and post-RUN busy cycles.
    task automatic run_session(input int idx, input bit hold, input int p,
                               output int cyc, output int runs, output int tail);
        cyc  = 0;
        runs = 0;
        tail = 0;
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_v[idx] = 1'b0;
        cyc = 1;
        chk("seed_done_low", done_v[idx], 1'b0);
        chk("seed_busy", busy_v[idx], 1'b1);
        while (!done_v[idx] && cyc < 400) begin
            if (!lrst_v[idx]) runs++;
            if (busy_v[idx] && cnt_v[idx] == 16'(p)) tail++;
            @(posedge clk);
            #1;
            cyc++;
        end
        start_v[idx] = 1'b0;
        if (!done_v[idx]) chk("timeout", 32'd0, 32'd1);
    endtask

    int         cyc, runs, tail;
    logic [7:0] ref255;
    logic [7:0] first_sig;

    initial begin
        rst     = 1'b1;
        start_v = '0;
        ref255  = ref_sig(255);
        #1;
        for (int i = 1; i <= 5; i++) begin
            chk("rst_lfsr_rst", lrst_v[i], 1'b1);
            chk("rst_test_mode", tm_v[i], 1'b0);
            chk("rst_busy", busy_v[i], 1'b0);
            chk("rst_done", done_v[i], 1'b0);
            chk("rst_pass", pass_v[i], 1'b0);
            chk("rst_sig", sig_v[i], 8'h00);
            chk("rst_cnt", cnt_v[i], 16'h0000);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: single pattern, identity CUT
        run_session(1, 1'b0, 1, cyc, runs, tail);
        chk("t1_len", cyc, 4);
        chk("t1_sig", sig_v[1], 8'hA5);
        chk("t1_pass", pass_v[1], 1'b1);
        chk("t1_done", done_v[1], 1'b1);
        chk("t1_cnt", cnt_v[1], 16'd1);
        chk("t1_runs", runs, 1);
        chk("t1_tm_done", tm_v[1], 1'b0);
        chk("t1_busy_done", busy_v[1], 1'b0);

        // 2: two patterns A5, 57 -> signature 00
        run_session(2, 1'b0, 2, cyc, runs, tail);
        chk("t2_len", cyc, 5);
        chk("t2_sig", sig_v[2], 8'h00);
        chk("t2_pass", pass_v[2], 1'b1);
        chk("t2_cnt", cnt_v[2], 16'd2);

        // 3: same data, wrong golden
        run_session(3, 1'b0, 2, cyc, runs, tail);
        chk("t3_sig", sig_v[3], 8'h00);
        chk("t3_pass", pass_v[3], 1'b0);
        chk("t3_done", done_v[3], 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_hold_sig", sig_v[3], 8'h00);
        chk("t3_hold_done", done_v[3], 1'b1);

        // 4: CUT with 2 cycles of latency
        run_session(4, 1'b0, 255, cyc, runs, tail);
        chk("t4_len", cyc, 260);
        chk("t4_sig", sig_v[4], ref255);
        chk("t4_pass", pass_v[4], (ref255 == 8'h00));
        chk("t4_runs", runs, 255);
        chk("t4_flush_check", tail, 3);

        // 5: async reset at RUN cycle 10, then a clean full run
        @(negedge clk);
        start_v[5] = 1'b1;
        @(posedge clk);
        #1;
        start_v[5] = 1'b0;
        cyc = 0;
        while (cnt_v[5] != 16'd10 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t5_reach_run10", cnt_v[5], 16'd10);
        chk("t5_busy_pre", busy_v[5], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_lfsr_rst", lrst_v[5], 1'b1);
        chk("t5_test_mode", tm_v[5], 1'b0);
        chk("t5_busy", busy_v[5], 1'b0);
        chk("t5_done", done_v[5], 1'b0);
        chk("t5_sig", sig_v[5], 8'h00);
        chk("t5_cnt", cnt_v[5], 16'd0);
        @(negedge clk);
        rst = 1'b0;
        run_session(5, 1'b0, 255, cyc, runs, tail);
        chk("t5_len", cyc, 258);
        chk("t5_sig_full", sig_v[5], ref255);
        chk("t5_pass_full", pass_v[5], (ref255 == 8'h00));
        chk("t5_runs", runs, 255);
        chk("t5_tail", tail, 1);

        // 6: start held through the session, then a single pulse from DONE
        run_session(5, 1'b1, 255, cyc, runs, tail);
        chk("t6_len_held", cyc, 258);
        chk("t6_runs_held", runs, 255);
        chk("t6_cnt_held", cnt_v[5], 16'd255);
        first_sig = sig_v[5];
        chk("t6_sig_held", first_sig, ref255);
        @(posedge clk);
        #1;
        chk("t6_idle_in_done", done_v[5], 1'b1);
        run_session(5, 1'b0, 255, cyc, runs, tail);
        chk("t6_len_rerun", cyc, 258);
        chk("t6_sig_rerun", sig_v[5], first_sig);
        chk("t6_done_rerun", done_v[5], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
